instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv32e_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 48 ++++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32e_pkg.sv
// rtl/rv32e_pkg.sv - shared widths, reset address and fetch entry type for the fetch slice
package rv32e_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch stride; wraps silently at the top of the address space.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - redirect, instruction-memory and decode handshakes of the fetch unit
interface instr_fetch_if;
  import rv32e_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  redirect_valid,
    input  redirect_addr,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_addr,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous instruction buffer with flush
// Storage resets so an empty buffer after reset presents {RESET_ADDR, 0} at the head.
module fetch_fifo import rv32e_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int              DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL) || do_pop);

  // Flush wins over push/pop: a popped head in a flush cycle is simply gone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_ADDR, instr: '0};
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - in-order instruction fetch with redirect and bounded in-flight budget
// live/drop track outstanding requests whose responses are kept or discarded after a redirect.
module instr_fetch import rv32e_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int              DEPTH      = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [CW:0] BUDGET = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   live;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW:0]     used;

  logic            req_hs;
  logic            rsp_kept;
  logic            rsp_drop;
  logic            pop;
  logic            head_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Buffer slots are reserved at request time so a response can never find the buffer full.
  assign used               = {1'b0, live} + {1'b0, drop} + {1'b0, count};
  assign bus.imem_req_valid = rst && (used < BUDGET);
  assign bus.imem_req_addr  = fetch_pc;

  assign req_hs     = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_kept   = bus.imem_rsp_valid && !bus.redirect_valid && (drop == '0);
  assign rsp_drop   = bus.imem_rsp_valid && !bus.redirect_valid && (drop != '0);
  assign pop        = head_valid && bus.inst_ready;
  assign push_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_ADDR;
      rsp_pc   <= RESET_ADDR;
      live     <= '0;
      drop     <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still outstanding, including a request accepted this cycle, becomes stale.
      fetch_pc <= bus.redirect_addr;
      rsp_pc   <= bus.redirect_addr;
      live     <= '0;
      drop     <= live + drop + {{(CW-1){1'b0}}, req_hs}
                              - {{(CW-1){1'b0}}, bus.imem_rsp_valid};
    end else begin
      if (req_hs) begin
        fetch_pc <= next_pc(fetch_pc);
      end
      live <= live + {{(CW-1){1'b0}}, req_hs} - {{(CW-1){1'b0}}, rsp_kept};
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
      if (rsp_kept) begin
        rsp_pc <= next_pc(rsp_pc);
      end
    end
  end

  fetch_fifo #(
    .RESET_ADDR (RESET_ADDR),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (rsp_kept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .valid     (head_valid),
    .count     (count)
  );

  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = head.instr;
  assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized checks of instr_fetch against a queue-based model
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_ADDR (RST_ADDR),
    .DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          hs_count;
  logic [31:0] last_hs_addr;
  logic [31:0] exp_req_addr;
  req_t        infl[$];
  ent_t        buf_q[$];
  ent_t        popped[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.inst_ready     = 1'b0;
  endtask

  // Asserts reset (memory model resets with it), checks reset outputs, releases after hold cycles.
  task automatic do_reset(input int hold);
    rst = 1'b0;
    drive_idle();
    #1;
    chk_b("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk_b("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, RST_ADDR);
    infl.delete();
    buf_q.delete();
    exp_req_addr = RST_ADDR;
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  // One clock: compare outputs to the model, drive inputs, advance the model, then clock.
  // rmode: 0 = memory silent, 1 = respond as soon as due, 2 = respond randomly once due.
  task automatic step(input bit redir, input logic [31:0] raddr, input bit rdy,
                      input bit irdy, input int rmode);
    bit   exp_rv;
    bit   hs;
    bit   pop;
    bit   rsp;
    bit   have_push;
    req_t r;
    ent_t e;

    exp_rv = (infl.size() + buf_q.size()) < DEPTH;
    chk_b("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, exp_req_addr);
    chk_b("inst_valid", bus.inst_valid, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      chk("inst_pc", bus.inst_pc, buf_q[0].pc);
      chk("inst_data", bus.inst_data, buf_q[0].data);
    end

    rsp = 1'b0;
    if (infl.size() != 0 && infl[0].due <= cyc)
      rsp = (rmode == 1) || (rmode == 2 && $urandom_range(0, 2) != 0);
    hs  = exp_rv && rdy;
    pop = (buf_q.size() != 0) && irdy;

    bus.redirect_valid = redir;
    bus.redirect_addr  = raddr;
    bus.imem_req_ready = rdy;
    bus.inst_ready     = irdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(infl[0].addr) : 32'h0;

    if (pop) begin
      popped.push_back(buf_q[0]);
      void'(buf_q.pop_front());
    end
    have_push = 1'b0;
    if (rsp) begin
      r = infl.pop_front();
      if (!redir && !r.stale) begin
        e.pc      = r.addr;
        e.data    = mem_word(r.addr);
        have_push = 1'b1;
      end
    end
    if (hs) begin
      hs_count++;
      last_hs_addr = exp_req_addr;
      infl.push_back('{addr: exp_req_addr, stale: redir, due: cyc + 1});
      if (!redir) exp_req_addr = exp_req_addr + 32'd4;
    end
    if (redir) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      buf_q.delete();
      exp_req_addr = raddr;
    end
    if (have_push) buf_q.push_back(e);

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_pops(input string tag, input int n, input int bound,
                                input bit rdy, input bit irdy, input int rmode);
    for (int k = 0; k < bound && popped.size() < n; k++) step(1'b0, 32'h0, rdy, irdy, rmode);
    chk_b(tag, popped.size() >= n, 1'b1);
  endtask

  initial begin
    bit          redir;
    logic [31:0] raddr;

    rst = 1'b1;
    drive_idle();
    #3;
    do_reset(3);

    // Straight-line fetch from reset with an always-ready memory and decode
    popped.delete();
    run_until_pops("seq_pops", 4, 40, 1'b1, 1'b1, 1);
    if (popped.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("seq_pc", popped[i].pc, RST_ADDR + 32'(4 * i));
        chk("seq_data", popped[i].data, mem_word(RST_ADDR + 32'(4 * i)));
      end
    end

    // Decode stalled: the budget admits exactly DEPTH requests
    do_reset(2);
    hs_count = 0;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    chk("stall_hs_count", 32'(hs_count), 32'd2);
    chk_b("stall_req_valid", bus.imem_req_valid, 1'b0);
    hs_count = 0;
    for (int k = 0; k < 10 && hs_count == 0; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("resume_addr", last_hs_addr, 32'h8);

    // Redirect with two requests outstanding
    do_reset(2);
    step(1'b0, 32'h0, 1'b1, 1'b0, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 0);
    chk("inflight_before_redirect", 32'(infl.size()), 32'd2);
    step(1'b1, 32'h100, 1'b0, 1'b0, 0);
    popped.delete();
    run_until_pops("redir_pops", 1, 30, 1'b1, 1'b1, 1);
    if (popped.size() >= 1) chk("redir_first_pc", popped[0].pc, 32'h100);

    // Redirect in the same cycle as a pop and a response
    do_reset(2);
    popped.delete();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk_b("collide_head_ready", bus.inst_valid, 1'b1);
    chk_b("collide_rsp_due", (infl.size() != 0) && (infl[0].due <= cyc), 1'b1);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1);
    chk("collide_pops", 32'(popped.size()), 32'd1);
    if (popped.size() >= 1) chk("collide_pop_pc", popped[0].pc, 32'h0);
    chk_b("collide_no_stale", bus.inst_valid, 1'b0);
    run_until_pops("collide_pops2", 2, 30, 1'b1, 1'b1, 1);
    if (popped.size() >= 2) chk("collide_next_pc", popped[1].pc, 32'h200);

    // Redirect to the last word: fetch wraps to zero
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 0);
    popped.delete();
    run_until_pops("wrap_pops", 2, 40, 1'b1, 1'b1, 1);
    if (popped.size() >= 2) begin
      chk("wrap_pc0", popped[0].pc, 32'hFFFF_FFFC);
      chk("wrap_pc1", popped[1].pc, 32'h0);
      chk("wrap_data1", popped[1].data, mem_word(32'h0));
    end

    // Reset mid-stream with two requests outstanding
    do_reset(2);
    step(1'b0, 32'h0, 1'b1, 1'b0, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 0);
    do_reset(2);
    chk_b("post_rst_req_valid", bus.imem_req_valid, 1'b1);
    chk("post_rst_req_addr", bus.imem_req_addr, RST_ADDR);

    // Randomized traffic, redirects and occasional resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(2);
      end else begin
        redir = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 3))
          0:       raddr = 32'hFFFF_FFF8;
          default: raddr = $urandom() & 32'hFFFF_FFFC;
        endcase
        step(redir, raddr, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
